// File: rtl/pio_input_debounce.sv
// Per-bit synchroniser and debouncer for slide switches and push-buttons.
// Ports: clk, reset_n (async low), raw_in -> db_out level, rise/fall/changed strobes.
module pio_input_debounce #(
    parameter int               WIDTH        = 10,
    parameter int               TICK_DIV     = 50000,
    parameter int               STABLE_TICKS = 8,
    parameter logic [WIDTH-1:0] INIT         = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] C_LAST = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_db;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_changed;
    logic [PW-1:0]    r_pre;
    logic [CW-1:0]    r_cnt [WIDTH];

    logic             w_tick;
    logic [WIDTH-1:0] w_db_nxt;
    logic [WIDTH-1:0] w_rise_nxt;
    logic [WIDTH-1:0] w_fall_nxt;
    logic [CW-1:0]    w_cnt_nxt [WIDTH];

    // With TICK_DIV=1 the prescaler is a constant 0, so tick is always high.
    assign w_tick = (r_pre == P_LAST);

    // A bit matching the held level clears its count every cycle, so any
    // glitch back to the old level restarts qualification from zero.
    always_comb begin
        w_db_nxt   = r_db;
        w_rise_nxt = '0;
        w_fall_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (r_sync2[i] == r_db[i]) begin
                w_cnt_nxt[i] = '0;
            end else if (w_tick && (r_cnt[i] == C_LAST)) begin
                w_cnt_nxt[i]  = '0;
                w_db_nxt[i]   = r_sync2[i];
                w_rise_nxt[i] = r_sync2[i];
                w_fall_nxt[i] = ~r_sync2[i];
            end else if (w_tick) begin
                w_cnt_nxt[i] = r_cnt[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= INIT;
            r_sync2   <= INIT;
            r_db      <= INIT;
            r_rise    <= '0;
            r_fall    <= '0;
            r_changed <= 1'b0;
            r_pre     <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1   <= raw_in;
            r_sync2   <= r_sync1;
            r_db      <= w_db_nxt;
            r_rise    <= w_rise_nxt;
            r_fall    <= w_fall_nxt;
            r_changed <= |(w_rise_nxt | w_fall_nxt);
            r_pre     <= w_tick ? '0 : r_pre + PW'(1);
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign db_out  = r_db;
    assign rise    = r_rise;
    assign fall    = r_fall;
    assign changed = r_changed;

endmodule

// File: tb/tb_pio_input_debounce.sv
// Testbench for pio_input_debounce: directed steps with a strobe scoreboard.
// Instance A: TICK_DIV=1, STABLE_TICKS=4. Instance B: TICK_DIV=5, STABLE_TICKS=3.
module tb_pio_input_debounce;

    typedef struct {
        logic [9:0] db;
        logic [9:0] rise;
        logic [9:0] fall;
        int         lo;
        int         hi;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [9:0] raw_a = 10'h3FF;
    logic [9:0] raw_b = 10'h000;
    logic [9:0] db_a, rise_a, fall_a;
    logic [9:0] db_b, rise_b, fall_b;
    logic       chg_a, chg_b;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    exp_t qa[$];
    exp_t qb[$];

    pio_input_debounce #(
        .WIDTH(10), .TICK_DIV(1), .STABLE_TICKS(4), .INIT(10'h000)
    ) u_a (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_a),
        .db_out(db_a), .rise(rise_a), .fall(fall_a), .changed(chg_a)
    );

    pio_input_debounce #(
        .WIDTH(10), .TICK_DIV(5), .STABLE_TICKS(3), .INIT(10'h000)
    ) u_b (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_b),
        .db_out(db_b), .rise(rise_b), .fall(fall_b), .changed(chg_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [9:0] obs,
                       input logic [9:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs,
                           input int lo, input int hi);
        vectors++;
        assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
            miscompares++;
            $error("FAIL %s: got %0d want %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic push_a(input logic [9:0] d, input logic [9:0] r,
                          input logic [9:0] f, input int lo, input int hi);
        exp_t e;
        e.db = d; e.rise = r; e.fall = f; e.lo = lo; e.hi = hi;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic [9:0] d, input logic [9:0] r,
                          input logic [9:0] f, input int lo, input int hi);
        exp_t e;
        e.db = d; e.rise = r; e.fall = f; e.lo = lo; e.hi = hi;
        qb.push_back(e);
    endtask

    task automatic observe();
        exp_t e;
        if (chg_a) begin
            if (qa.size() == 0) begin
                chk("a_spurious", 10'(chg_a), 10'h000);
            end else begin
                e = qa.pop_front();
                chk("a_db", db_a, e.db);
                chk("a_rise", rise_a, e.rise);
                chk("a_fall", fall_a, e.fall);
                chk_rng("a_cycle", cyc, e.lo, e.hi);
            end
        end else begin
            chk("a_quiet", rise_a | fall_a, 10'h000);
        end
        if (chg_b) begin
            if (qb.size() == 0) begin
                chk("b_spurious", 10'(chg_b), 10'h000);
            end else begin
                e = qb.pop_front();
                chk("b_db", db_b, e.db);
                chk("b_rise", rise_b, e.rise);
                chk("b_fall", fall_b, e.fall);
                chk_rng("b_cycle", cyc, e.lo, e.hi);
            end
        end else begin
            chk("b_quiet", rise_b | fall_b, 10'h000);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            observe();
        end
    endtask

    task automatic edge_a(input logic [9:0] v, input logic [9:0] d,
                          input logic [9:0] r, input logic [9:0] f,
                          input string tag);
        raw_a = v;
        push_a(d, r, f, cyc + 6, cyc + 6);
        step(10);
        chk_rng(tag, qa.size(), 0, 0);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            observe();
            chk("rst_db_a", db_a, 10'h000);
            chk("rst_db_b", db_b, 10'h000);
            chk("rst_chg", 10'({chg_a, chg_b}), 10'h000);
        end
        raw_a = 10'h000;
        reset_n = 1'b1;
        step(4);

        raw_a = 10'h008; step(3);
        raw_a = 10'h000; step(1);
        raw_a = 10'h008; step(3);
        raw_a = 10'h000; step(8);
        chk("bounce_db", db_a, 10'h000);
        edge_a(10'h008, 10'h008, 10'h008, 10'h000, "bounce_hold");

        edge_a(10'h000, 10'h000, 10'h000, 10'h008, "fall3");
        edge_a(10'h001, 10'h001, 10'h001, 10'h000, "clean_step");
        edge_a(10'h004, 10'h004, 10'h004, 10'h001, "swap_0_2");
        edge_a(10'h200, 10'h200, 10'h200, 10'h004, "simul");
        edge_a(10'h000, 10'h000, 10'h000, 10'h200, "fall9");

        raw_a = 10'h020;
        step(3);
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            observe();
            chk("midrst_db", db_a, 10'h000);
        end
        reset_n = 1'b1;
        push_a(10'h020, 10'h020, 10'h000, cyc + 6, cyc + 6);
        step(10);
        chk_rng("midrst_done", qa.size(), 0, 0);

        for (int t = 0; t < 20; t++) begin
            step(int'($urandom_range(0, 4)));
            raw_b = 10'h002;
            push_b(10'h002, 10'h002, 10'h000, cyc + 13, cyc + 17);
            step(20);
            chk_rng("pre_rise", qb.size(), 0, 0);
            raw_b = 10'h000;
            push_b(10'h000, 10'h000, 10'h002, cyc + 13, cyc + 17);
            step(20);
            chk_rng("pre_fall", qb.size(), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
